m1_muldiv: RTL and testbench

//  Parametrised iterative multiply/divide unit for the M1 core; replaces the separate mul and div

---
 rtl/m1_muldiv_pkg.sv | 6 +
 rtl/m1_muldiv_if.sv | 18 +
 rtl/m1_muldiv_step.sv | 22 ++
 rtl/m1_muldiv.sv | 132 +++++++++++++
 tb/tb_m1_muldiv.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/m1_muldiv_pkg.sv
// m1_muldiv_pkg: shared FSM state and op encodings for the iterative mul/div unit
package m1_muldiv_pkg;
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
endpackage

// File: rtl/m1_muldiv_if.sv
// m1_muldiv_if: abp req/ack handshake, operands and results between CPU and mul/div unit
interface m1_muldiv_if #(parameter int WIDTH = 32);
  logic             abp_req_i;
  logic             op_i;
  logic             signed_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             kill_i;
  logic             abp_ack_o;
  logic             busy_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             div_zero_o;
  modport master (output abp_req_i, op_i, signed_i, a_i, b_i, kill_i,
                  input abp_ack_o, busy_o, hi_o, lo_o, div_zero_o);
  modport slave (input abp_req_i, op_i, signed_i, a_i, b_i, kill_i,
                 output abp_ack_o, busy_o, hi_o, lo_o, div_zero_o);
endinterface

// File: rtl/m1_muldiv_step.sv
// m1_muldiv_step: one iteration of shift-add multiply or restoring divide on a 2W accumulator
module m1_muldiv_step import m1_muldiv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic               op_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   m_i,
  output logic [2*WIDTH-1:0] acc_o
);
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] div_nxt;
  // mul: lo holds the multiplier, its lsb gates the add into hi; carry shifts back in
  assign sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, m_i} : '0);
  assign mul_nxt = {sum, acc_i[WIDTH-1:1]};
  // div: shifted partial remainder needs W+1 bits before the trial subtract
  assign trial   = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, m_i};
  assign div_nxt = trial[WIDTH] ? {acc_i[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
  assign acc_o   = (op_i == OP_DIV) ? div_nxt : mul_nxt;
endmodule

// File: rtl/m1_muldiv.sv
// m1_muldiv: shared iterative multiply/divide unit with sign fix-up, divide-by-zero flag and kill
module m1_muldiv import m1_muldiv_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic         sys_clock_i,
  input logic         sys_reset_i,
  m1_muldiv_if.slave  bus
);
  localparam int W = WIDTH;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic               op_q, op_d;
  logic               sgn_q, sgn_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               dz_q, dz_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*W-1:0]     acc_q, acc_d, acc_step;
  logic               sa, sb, dz;
  logic [W-1:0]       a_mag, b_mag;
  assign sa    = sgn_q & a_q[W-1];
  assign sb    = sgn_q & b_q[W-1];
  assign a_mag = sa ? -a_q : a_q;
  assign b_mag = sb ? -b_q : b_q;
  assign dz    = (op_q == OP_DIV) && (b_q == '0);
  m1_muldiv_step #(.WIDTH(W)) u_step (
    .op_i  (op_q),
    .acc_i (acc_q),
    .m_i   (m_q),
    .acc_o (acc_step)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    op_d    = op_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    if (state_q != IDLE && bus.kill_i) begin
      state_d = IDLE;
      armed_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.abp_req_i) armed_d = 1'b1;
          else if (armed_q && !bus.kill_i) begin
            armed_d = 1'b0;
            op_d    = bus.op_i;
            sgn_d   = bus.signed_i;
            a_d     = bus.a_i;
            b_d     = bus.b_i;
            state_d = PREP;
          end
        end
        PREP: begin
          negq_d  = sa ^ sb;
          negr_d  = sa;
          m_d     = (op_q == OP_DIV) ? b_mag : a_mag;
          acc_d   = {{W{1'b0}}, (op_q == OP_DIV) ? a_mag : b_mag};
          cnt_d   = CNT_W'(W - 1);
          state_d = CALC;
        end
        CALC: begin
          acc_d   = acc_step;
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_q == '0) ? FIX : CALC;
        end
        FIX: begin
          dz_d = dz;
          if (op_q == OP_MUL) {hi_d, lo_d} = negq_q ? -acc_q : acc_q;
          else begin
            // b=0 overrides the fix-up: raw dividend back, quotient all ones
            lo_d = dz ? '1 : (negq_q ? -acc_q[W-1:0] : acc_q[W-1:0]);
            hi_d = dz ? a_q : (negr_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W]);
          end
          state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge sys_clock_i or negedge sys_reset_i) begin
    if (!sys_reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      op_q    <= 1'b0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
    end
  end
  // kill masks the done pulse in the same cycle
  assign bus.abp_ack_o  = (state_q == DONE) && !bus.kill_i;
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;
  assign bus.div_zero_o = dz_q;
endmodule

// File: tb/tb_m1_muldiv.sv
// tb_m1_muldiv: directed checks of m1_muldiv results, latency, kill, reset and re-arm behaviour
module tb_m1_muldiv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  m1_muldiv_if #(.WIDTH(32)) bus ();
  m1_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .sys_clock_i (clk),
    .sys_reset_i (rst_n),
    .bus         (bus)
  );
  always #5 clk = ~clk;

  task automatic run_op(input logic op, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int lat, output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz, output logic ack2);
    bus.abp_req_i = 1'b0;
    bus.kill_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.op_i = op;
    bus.signed_i = sgn;
    bus.a_i = a;
    bus.b_i = b;
    bus.abp_req_i = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      if (bus.abp_ack_o) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    hi = bus.hi_o;
    lo = bus.lo_o;
    dz = bus.div_zero_o;
    if (!hold) bus.abp_req_i = 1'b0;
    @(posedge clk);
    #1;
    ack2 = bus.abp_ack_o;
  endtask

  task automatic test_reset;
    bus.abp_req_i = 1'b0;
    bus.kill_i = 1'b0;
    bus.op_i = 1'b0;
    bus.signed_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    #12;
    checks++;
    if ({bus.abp_ack_o, bus.busy_o, bus.div_zero_o, bus.hi_o, bus.lo_o} !== 67'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b busy=%b dz=%b hi=%h lo=%h, expected all 0",
               bus.abp_ack_o, bus.busy_o, bus.div_zero_o, bus.hi_o, bus.lo_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul;
    int lat;
    logic [31:0] hi, lo;
    logic dz, ack2;
    run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, hi, lo, dz, ack2);
    checks++;
    if (lat !== 35) begin errors++; $display("FAIL umul_latency: got %0d expected 35", lat); end
    checks++;
    if (ack2 !== 1'b0) begin errors++; $display("FAIL umul_ack_width: ack still %b next cycle, expected 0", ack2); end
    checks++;
    if ({hi, lo, dz} !== {32'hFFFFFFFE, 32'h00000001, 1'b0}) begin
      errors++; $display("FAIL umul_max: got hi=%h lo=%h dz=%b expected FFFFFFFE 00000001 0", hi, lo, dz);
    end
    run_op(1'b0, 1'b1, 32'hFFFFFFFD, 32'd7, 1'b0, lat, hi, lo, dz, ack2);
    checks++;
    if ({hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFFEB}) begin
      errors++; $display("FAIL smul_neg3x7: got hi=%h lo=%h expected FFFFFFFF FFFFFFEB", hi, lo);
    end
    run_op(1'b0, 1'b0, 32'hFFFFFFFD, 32'd7, 1'b0, lat, hi, lo, dz, ack2);
    checks++;
    if ({hi, lo} !== {32'h00000006, 32'hFFFFFFEB}) begin
      errors++; $display("FAIL umul_fffffffdx7: got hi=%h lo=%h expected 00000006 FFFFFFEB", hi, lo);
    end
    run_op(1'b0, 1'b1, 32'h80000000, 32'h80000000, 1'b0, lat, hi, lo, dz, ack2);
    checks++;
    if ({hi, lo} !== {32'h40000000, 32'h00000000}) begin
      errors++; $display("FAIL smul_min_min: got hi=%h lo=%h expected 40000000 00000000", hi, lo);
    end
  endtask

  task automatic test_div;
    int lat;
    logic [31:0] hi, lo;
    logic dz, ack2;
    run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, lat, hi, lo, dz, ack2);
    checks++;
    if ({hi, lo, dz} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0}) begin
      errors++; $display("FAIL sdiv_neg7_2: got hi=%h lo=%h dz=%b expected FFFFFFFF FFFFFFFD 0", hi, lo, dz);
    end
    run_op(1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, 1'b0, lat, hi, lo, dz, ack2);
    checks++;
    if ({hi, lo} !== {32'h00000001, 32'hFFFFFFFD}) begin
      errors++; $display("FAIL sdiv_7_neg2: got hi=%h lo=%h expected 00000001 FFFFFFFD", hi, lo);
    end
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, lat, hi, lo, dz, ack2);
    checks++;
    if ({hi, lo, lat} !== {32'd2, 32'd14, 32'd35}) begin
      errors++; $display("FAIL udiv_100_7: got hi=%h lo=%h lat=%0d expected 00000002 0000000e 35", hi, lo, lat);
    end
    run_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, hi, lo, dz, ack2);
    checks++;
    if ({hi, lo, dz} !== {32'h00000000, 32'h80000000, 1'b0}) begin
      errors++; $display("FAIL sdiv_overflow: got hi=%h lo=%h dz=%b expected 00000000 80000000 0", hi, lo, dz);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    logic [31:0] hi, lo;
    logic dz, ack2;
    for (int s = 0; s < 2; s++) begin
      run_op(1'b1, s[0], 32'h00001234, 32'd0, 1'b0, lat, hi, lo, dz, ack2);
      checks++;
      if ({hi, lo, dz, lat} !== {32'h00001234, 32'hFFFFFFFF, 1'b1, 32'd35}) begin
        errors++;
        $display("FAIL div_zero_s%0d: got hi=%h lo=%h dz=%b lat=%0d expected 00001234 FFFFFFFF 1 35", s, hi, lo, dz, lat);
      end
    end
    run_op(1'b1, 1'b1, 32'hFFFFFFF0, 32'd0, 1'b0, lat, hi, lo, dz, ack2);
    checks++;
    if ({hi, lo, dz} !== {32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1}) begin
      errors++; $display("FAIL div_zero_neg: got hi=%h lo=%h dz=%b expected FFFFFFF0 FFFFFFFF 1", hi, lo, dz);
    end
    checks++;
    if (bus.div_zero_o !== 1'b1) begin errors++; $display("FAIL div_zero_hold: got %b expected 1", bus.div_zero_o); end
    run_op(1'b0, 1'b0, 32'd5, 32'd6, 1'b0, lat, hi, lo, dz, ack2);
    checks++;
    if ({hi, lo, dz} !== {32'd0, 32'd30, 1'b0}) begin
      errors++; $display("FAIL div_zero_clear: got hi=%h lo=%h dz=%b expected 00000000 0000001e 0", hi, lo, dz);
    end
  endtask

  task automatic test_kill;
    int acks;
    bus.abp_req_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.op_i = 1'b0; bus.signed_i = 1'b0; bus.a_i = 32'h12345678; bus.b_i = 32'd9;
    bus.abp_req_i = 1'b1;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    bus.kill_i = 1'b1;
    bus.abp_req_i = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy_o, bus.abp_ack_o} !== 2'b00) begin
      errors++; $display("FAIL kill_calc_idle: got busy=%b ack=%b expected 0 0", bus.busy_o, bus.abp_ack_o);
    end
    bus.kill_i = 1'b0;
    acks = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.abp_ack_o) acks++; end
    checks++;
    if ({acks, bus.hi_o, bus.lo_o, bus.div_zero_o} !== {32'd0, 32'd0, 32'd30, 1'b0}) begin
      errors++; $display("FAIL kill_calc_keep: got acks=%0d hi=%h lo=%h dz=%b expected 0 00000000 0000001e 0",
                         acks, bus.hi_o, bus.lo_o, bus.div_zero_o);
    end
    // kill during DONE: pulse must vanish in the same cycle
    bus.op_i = 1'b0; bus.a_i = 32'd3; bus.b_i = 32'd3;
    @(negedge clk);
    bus.abp_req_i = 1'b1;
    @(posedge clk);
    #1;
    repeat (34) @(posedge clk);
    #1;
    bus.kill_i = 1'b1;
    bus.abp_req_i = 1'b0;
    #1;
    checks++;
    if ({bus.busy_o, bus.abp_ack_o, bus.lo_o} !== {1'b1, 1'b0, 32'd9}) begin
      errors++; $display("FAIL kill_done_mask: got busy=%b ack=%b lo=%h expected 1 0 00000009", bus.busy_o, bus.abp_ack_o, bus.lo_o);
    end
    @(posedge clk);
    #1;
    bus.kill_i = 1'b0;
    // kill and req together in IDLE: no accept
    @(negedge clk);
    bus.a_i = 32'd2; bus.b_i = 32'd2;
    bus.kill_i = 1'b1;
    bus.abp_req_i = 1'b1;
    acks = 0;
    repeat (3) begin @(posedge clk); #1; if (bus.busy_o) acks++; end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL kill_idle_block: busy seen %0d cycles expected 0", acks); end
    bus.kill_i = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL kill_release_accept: got busy=%b expected 1", bus.busy_o); end
    acks = 0;
    for (int n = 0; n < 60 && acks == 0; n++) begin @(posedge clk); #1; if (bus.abp_ack_o) acks = 1; end
    bus.abp_req_i = 1'b0;
    checks++;
    if ({acks, bus.lo_o} !== {32'd1, 32'd4}) begin errors++; $display("FAIL kill_after_op: got ack=%0d lo=%h expected 1 00000004", acks, bus.lo_o); end
  endtask

  task automatic test_async_reset;
    int acks;
    bus.abp_req_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.op_i = 1'b0; bus.a_i = 32'hFFFFFFFF; bus.b_i = 32'hFFFFFFFF;
    bus.abp_req_i = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.abp_ack_o, bus.busy_o, bus.div_zero_o, bus.hi_o, bus.lo_o} !== 67'd0) begin
      errors++; $display("FAIL reset_midop: got ack=%b busy=%b dz=%b hi=%h lo=%h expected all 0",
                         bus.abp_ack_o, bus.busy_o, bus.div_zero_o, bus.hi_o, bus.lo_o);
    end
    bus.abp_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.abp_ack_o || bus.busy_o) acks++; end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL reset_no_ack: got %0d active cycles expected 0", acks); end
  endtask

  task automatic test_back_to_back;
    int lat, busy_n;
    logic [31:0] hi, lo;
    logic dz, ack2;
    run_op(1'b0, 1'b0, 32'd11, 32'd13, 1'b1, lat, hi, lo, dz, ack2);
    checks++;
    if ({lo, lat} !== {32'd143, 32'd35}) begin errors++; $display("FAIL hold_first: got lo=%h lat=%0d expected 0000008f 35", lo, lat); end
    bus.a_i = 32'd100; bus.b_i = 32'd3; bus.op_i = 1'b1;
    busy_n = 0;
    repeat (5) begin @(posedge clk); #1; if (bus.busy_o || bus.abp_ack_o) busy_n++; end
    checks++;
    if (busy_n !== 0) begin errors++; $display("FAIL hold_no_restart: got %0d active cycles expected 0", busy_n); end
    @(negedge clk);
    bus.abp_req_i = 1'b0;
    @(negedge clk);
    bus.abp_req_i = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      if (bus.abp_ack_o) begin lat = n; break; end
      @(posedge clk);
      #1;
    end
    bus.abp_req_i = 1'b0;
    checks++;
    if ({bus.hi_o, bus.lo_o, lat} !== {32'd1, 32'd33, 32'd35}) begin
      errors++; $display("FAIL rearm_second: got hi=%h lo=%h lat=%0d expected 00000001 00000021 35", bus.hi_o, bus.lo_o, lat);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_kill();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
